// File: rtl/vend_request_panel.sv
// vend_request_panel
//   Customer-side initiator for the vending purchase interface. Collects coins, a
//   product code and a quantity. Issues one purchase request to the vend engine and
//   consumes its result. Then returns change, or a full refund, to the coin return.
//
//   Optional feature: define PANEL_TIMEOUT_EN to abort a WAIT that sees no response
//   within TIMEOUT_CYCLES cycles. The abort gives a full refund and sets error_light.
//
// Ports
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   coin_valid/value     coin insert strobe and coin value
//   select_valid/code    product-select strobe and product code
//   qty_valid/qty        quantity-entry strobe and quantity (a quantity of 0 is ignored)
//   cancel               customer abort strobe
//   req_valid/req_ready  purchase request handshake toward the vend engine
//   customer_money       credit offered with the request
//   customer_request     latched product code
//   quantity_request     latched quantity
//   resp_*               vend engine result: strobe, refusal flag, remaining money
//   change_valid/amount  one-cycle change pulse and the amount returned
//   coin_reject          one-cycle pulse: the last coin was not taken
//   error_light          the last purchase was refused or aborted
//   busy                 a transaction is in flight (REQUEST, WAIT or REFUND)
module vend_request_panel #(
    parameter int unsigned MAX_CREDIT     = 15,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       coin_valid,
    input  logic [3:0] coin_value,
    input  logic       select_valid,
    input  logic [2:0] select_code,
    input  logic       qty_valid,
    input  logic [3:0] qty,
    input  logic       cancel,
    output logic       req_valid,
    input  logic       req_ready,
    output logic [3:0] customer_money,
    output logic [2:0] customer_request,
    output logic [3:0] quantity_request,
    input  logic       resp_valid,
    input  logic       resp_red_light,
    input  logic [3:0] resp_customer_money,
    output logic       change_valid,
    output logic [3:0] change_amount,
    output logic       coin_reject,
    output logic       error_light,
    output logic       busy
);

    typedef enum logic [2:0] {StIdle, StCollect, StRequest, StWait, StRefund} state_e;

    state_e     state_q, state_d;
    logic [3:0] credit_q, credit_d;
    logic [2:0] sel_q, sel_d;
    logic       sel_vld_q, sel_vld_d;
    logic [3:0] qty_q, qty_d;
    logic       qty_vld_q, qty_vld_d;
    logic [3:0] change_q, change_d;
    logic       error_q, error_d;
    logic       coin_reject_q, coin_reject_d;

    logic [4:0] coin_sum;
    logic       coin_fits;
    logic [3:0] resp_clamped;
    logic       timeout_hit;

    // Extra bit so that an overflowing sum is seen and not wrapped.
    assign coin_sum     = {1'b0, credit_q} + {1'b0, coin_value};
    assign coin_fits    = (coin_sum <= 5'(MAX_CREDIT));
    // The engine can never hand back more than was offered.
    assign resp_clamped = (resp_customer_money > credit_q) ? credit_q : resp_customer_money;

`ifdef PANEL_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CntW-1:0] wait_cnt_q, wait_cnt_d;

    always_comb begin
        wait_cnt_d = '0;
        if (state_q == StWait) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // The counter starts at 0 on the first WAIT cycle, so WAIT lasts exactly TIMEOUT_CYCLES.
    assign timeout_hit = (wait_cnt_q == CntW'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        credit_d      = credit_q;
        sel_d         = sel_q;
        sel_vld_d     = sel_vld_q;
        qty_d         = qty_q;
        qty_vld_d     = qty_vld_q;
        change_d      = change_q;
        error_d       = error_q;
        coin_reject_d = 1'b0;

        unique case (state_q)
            StIdle, StCollect: begin
                if (cancel) begin
                    // Cancel beats a coin in the same cycle; that coin goes back out.
                    coin_reject_d = coin_valid;
                    if (credit_q != 4'd0) begin
                        change_d = credit_q;
                        state_d  = StRefund;
                    end else begin
                        sel_vld_d = 1'b0;
                        qty_vld_d = 1'b0;
                        state_d   = StIdle;
                    end
                end else begin
                    if (coin_valid) begin
                        if (coin_fits) begin
                            credit_d = coin_sum[3:0];
                            error_d  = 1'b0;
                            state_d  = StCollect;
                        end else begin
                            coin_reject_d = 1'b1;
                        end
                    end
                    if (select_valid) begin
                        sel_d     = select_code;
                        sel_vld_d = 1'b1;
                    end
                    if (qty_valid && (qty != 4'd0)) begin
                        qty_d     = qty;
                        qty_vld_d = 1'b1;
                    end
                    // Decide on next-state values so req_valid rises right after the
                    // completing strobe.
                    if ((credit_d != 4'd0) && sel_vld_d && qty_vld_d) begin
                        state_d = StRequest;
                    end
                end
            end
            StRequest: begin
                coin_reject_d = coin_valid;
                if (req_ready) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                coin_reject_d = coin_valid;
                if (resp_valid) begin
                    if (resp_red_light) begin
                        change_d = credit_q;
                        error_d  = 1'b1;
                    end else begin
                        change_d = resp_clamped;
                    end
                    state_d = StRefund;
                end else if (timeout_hit) begin
                    change_d = credit_q;
                    error_d  = 1'b1;
                    state_d  = StRefund;
                end
            end
            StRefund: begin
                coin_reject_d = coin_valid;
                credit_d      = 4'd0;
                sel_d         = 3'd0;
                sel_vld_d     = 1'b0;
                qty_d         = 4'd0;
                qty_vld_d     = 1'b0;
                state_d       = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            credit_q      <= 4'd0;
            sel_q         <= 3'd0;
            sel_vld_q     <= 1'b0;
            qty_q         <= 4'd0;
            qty_vld_q     <= 1'b0;
            change_q      <= 4'd0;
            error_q       <= 1'b0;
            coin_reject_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            sel_q         <= sel_d;
            sel_vld_q     <= sel_vld_d;
            qty_q         <= qty_d;
            qty_vld_q     <= qty_vld_d;
            change_q      <= change_d;
            error_q       <= error_d;
            coin_reject_q <= coin_reject_d;
        end
    end

    assign req_valid        = (state_q == StRequest);
    assign customer_money   = credit_q;
    assign customer_request = sel_q;
    assign quantity_request = qty_q;
    assign change_valid     = (state_q == StRefund);
    assign change_amount    = (state_q == StRefund) ? change_q : 4'd0;
    assign coin_reject      = coin_reject_q;
    assign error_light      = error_q;
    assign busy             = (state_q == StRequest) || (state_q == StWait) ||
                              (state_q == StRefund);

endmodule

// File: tb/tb_vend_request_panel.sv
module tb_vend_request_panel;
    localparam int unsigned TIMEOUT_CYCLES = 255;

    logic       clk = 1'b0;
    logic       rst;
    logic       coin_valid;
    logic [3:0] coin_value;
    logic       select_valid;
    logic [2:0] select_code;
    logic       qty_valid;
    logic [3:0] qty;
    logic       cancel;
    logic       req_valid;
    logic       req_ready;
    logic [3:0] customer_money;
    logic [2:0] customer_request;
    logic [3:0] quantity_request;
    logic       resp_valid;
    logic       resp_red_light;
    logic [3:0] resp_customer_money;
    logic       change_valid;
    logic [3:0] change_amount;
    logic       coin_reject;
    logic       error_light;
    logic       busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vend_request_panel #(
        .MAX_CREDIT    (15),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .coin_valid         (coin_valid),
        .coin_value         (coin_value),
        .select_valid       (select_valid),
        .select_code        (select_code),
        .qty_valid          (qty_valid),
        .qty                (qty),
        .cancel             (cancel),
        .req_valid          (req_valid),
        .req_ready          (req_ready),
        .customer_money     (customer_money),
        .customer_request   (customer_request),
        .quantity_request   (quantity_request),
        .resp_valid         (resp_valid),
        .resp_red_light     (resp_red_light),
        .resp_customer_money(resp_customer_money),
        .change_valid       (change_valid),
        .change_amount      (change_amount),
        .coin_reject        (coin_reject),
        .error_light        (error_light),
        .busy               (busy)
    );

    // Advance n rising edges and land 1 time unit after the last one.
    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_strobes();
        coin_valid   = 1'b0;
        select_valid = 1'b0;
        qty_valid    = 1'b0;
        cancel       = 1'b0;
        req_ready    = 1'b0;
        resp_valid   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_strobes();
        coin_value = 4'd0; select_code = 3'd0; qty = 4'd0;
        resp_red_light = 1'b0; resp_customer_money = 4'd0;
        tick(2);
        checks++;
        if ({req_valid, change_valid, coin_reject, error_light, busy} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected %b",
                     {req_valid, change_valid, coin_reject, error_light, busy}, 5'b0);
        end
        checks++;
        if ({customer_money, customer_request, quantity_request, change_amount} !== 15'b0) begin
            errors++;
            $display("FAIL reset_fields: got %h expected 0",
                     {customer_money, customer_request, quantity_request, change_amount});
        end
        rst = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_busy: got %b expected 0", busy);
        end
    endtask

    task automatic test_purchase();
        coin_valid = 1'b1; coin_value = 4'd5; tick();
        tick();
        coin_valid = 1'b0;
        select_valid = 1'b1; select_code = 3'd3; tick();
        select_valid = 1'b0;
        checks++;
        if (req_valid !== 1'b0) begin
            errors++;
            $display("FAIL purchase_early_req: got %b expected 0", req_valid);
        end
        qty_valid = 1'b1; qty = 4'd2; tick();
        qty_valid = 1'b0;
        checks++;
        if ({req_valid, busy} !== 2'b11) begin
            errors++;
            $display("FAIL purchase_req_valid: got %b expected 11", {req_valid, busy});
        end
        checks++;
        if ({customer_money, customer_request, quantity_request} !== {4'd10, 3'd3, 4'd2}) begin
            errors++;
            $display("FAIL purchase_req_fields: got %0d/%0d/%0d expected 10/3/2",
                     customer_money, customer_request, quantity_request);
        end
        req_ready = 1'b1; tick();
        req_ready = 1'b0;
        checks++;
        if ({req_valid, busy} !== 2'b01) begin
            errors++;
            $display("FAIL purchase_wait: got %b expected 01", {req_valid, busy});
        end
        resp_valid = 1'b1; resp_red_light = 1'b0; resp_customer_money = 4'd4; tick();
        resp_valid = 1'b0;
        checks++;
        if ({change_valid, change_amount, error_light} !== {1'b1, 4'd4, 1'b0}) begin
            errors++;
            $display("FAIL purchase_change: got v=%b amt=%0d err=%b expected v=1 amt=4 err=0",
                     change_valid, change_amount, error_light);
        end
        tick();
        checks++;
        if ({change_valid, busy} !== 2'b00) begin
            errors++;
            $display("FAIL purchase_rearm: got %b expected 00", {change_valid, busy});
        end
    endtask

    task automatic test_overflow();
        coin_valid = 1'b1; coin_value = 4'd12; tick();
        coin_valid = 1'b0;
        checks++;
        if (coin_reject !== 1'b0) begin
            errors++;
            $display("FAIL overflow_first_coin: got %b expected 0", coin_reject);
        end
        coin_valid = 1'b1; coin_value = 4'd5; tick();
        coin_valid = 1'b0;
        checks++;
        if (coin_reject !== 1'b1) begin
            errors++;
            $display("FAIL overflow_reject: got %b expected 1", coin_reject);
        end
        tick();
        checks++;
        if (coin_reject !== 1'b0) begin
            errors++;
            $display("FAIL overflow_reject_pulse: got %b expected 0", coin_reject);
        end
        // 12 + 3 = 15 sits exactly on the limit.
        coin_valid = 1'b1; coin_value = 4'd3; tick();
        coin_valid = 1'b0;
        checks++;
        if (coin_reject !== 1'b0) begin
            errors++;
            $display("FAIL overflow_limit_coin: got %b expected 0", coin_reject);
        end
        cancel = 1'b1; tick();
        cancel = 1'b0;
        checks++;
        if ({change_valid, change_amount} !== {1'b1, 4'd15}) begin
            errors++;
            $display("FAIL overflow_refund: got v=%b amt=%0d expected v=1 amt=15",
                     change_valid, change_amount);
        end
        tick();
    endtask

    task automatic test_backpressure_refused();
        // All three strobes together complete the request in one edge.
        coin_valid = 1'b1; coin_value = 4'd9;
        select_valid = 1'b1; select_code = 3'd1;
        qty_valid = 1'b1; qty = 4'd1;
        tick();
        clear_strobes();
        checks++;
        if ({req_valid, customer_money, customer_request, quantity_request} !==
            {1'b1, 4'd9, 3'd1, 4'd1}) begin
            errors++;
            $display("FAIL hold_start: got v=%b %0d/%0d/%0d expected v=1 9/1/1",
                     req_valid, customer_money, customer_request, quantity_request);
        end
        for (int i = 0; i < 10; i++) begin
            coin_valid = (i == 4); coin_value = 4'd1;
            resp_valid = (i == 6); resp_red_light = 1'b0; resp_customer_money = 4'd0;
            select_valid = (i == 2); select_code = 3'd6;
            tick();
            clear_strobes();
            checks++;
            if ({req_valid, customer_money, customer_request, quantity_request} !==
                {1'b1, 4'd9, 3'd1, 4'd1}) begin
                errors++;
                $display("FAIL hold_cycle%0d: got v=%b %0d/%0d/%0d expected v=1 9/1/1",
                         i, req_valid, customer_money, customer_request, quantity_request);
            end
            if (i == 4) begin
                checks++;
                if (coin_reject !== 1'b1) begin
                    errors++;
                    $display("FAIL hold_coin_reject: got %b expected 1", coin_reject);
                end
            end
        end
        req_ready = 1'b1; tick();
        req_ready = 1'b0;
        checks++;
        if ({req_valid, busy} !== 2'b01) begin
            errors++;
            $display("FAIL hold_accept: got %b expected 01", {req_valid, busy});
        end
        resp_valid = 1'b1; resp_red_light = 1'b1; resp_customer_money = 4'd3; tick();
        resp_valid = 1'b0; resp_red_light = 1'b0;
        checks++;
        if ({change_valid, change_amount, error_light} !== {1'b1, 4'd9, 1'b1}) begin
            errors++;
            $display("FAIL refused_refund: got v=%b amt=%0d err=%b expected v=1 amt=9 err=1",
                     change_valid, change_amount, error_light);
        end
        tick();
        checks++;
        if ({error_light, busy, change_valid} !== 3'b100) begin
            errors++;
            $display("FAIL refused_idle: got %b expected 100", {error_light, busy, change_valid});
        end
        coin_valid = 1'b1; coin_value = 4'd2; tick();
        coin_valid = 1'b0;
        checks++;
        if (error_light !== 1'b0) begin
            errors++;
            $display("FAIL refused_clear: got %b expected 0", error_light);
        end
        cancel = 1'b1; tick();
        cancel = 1'b0;
        checks++;
        if ({change_valid, change_amount} !== {1'b1, 4'd2}) begin
            errors++;
            $display("FAIL refused_cancel: got v=%b amt=%0d expected v=1 amt=2",
                     change_valid, change_amount);
        end
        tick();
    endtask

    task automatic test_clamp();
        coin_valid = 1'b1; coin_value = 4'd3;
        select_valid = 1'b1; select_code = 3'd5;
        qty_valid = 1'b1; qty = 4'd0;
        tick();
        clear_strobes();
        checks++;
        if (req_valid !== 1'b0) begin
            errors++;
            $display("FAIL clamp_qty_zero: got %b expected 0", req_valid);
        end
        qty_valid = 1'b1; qty = 4'd4; tick();
        qty_valid = 1'b0;
        checks++;
        if ({req_valid, customer_money, customer_request, quantity_request} !==
            {1'b1, 4'd3, 3'd5, 4'd4}) begin
            errors++;
            $display("FAIL clamp_req: got v=%b %0d/%0d/%0d expected v=1 3/5/4",
                     req_valid, customer_money, customer_request, quantity_request);
        end
        req_ready = 1'b1; tick();
        req_ready = 1'b0;
        resp_valid = 1'b1; resp_red_light = 1'b0; resp_customer_money = 4'd9; tick();
        resp_valid = 1'b0;
        checks++;
        if ({change_valid, change_amount, error_light} !== {1'b1, 4'd3, 1'b0}) begin
            errors++;
            $display("FAIL clamp_change: got v=%b amt=%0d err=%b expected v=1 amt=3 err=0",
                     change_valid, change_amount, error_light);
        end
        tick();
    endtask

    task automatic test_cancel_coin();
        coin_valid = 1'b1; coin_value = 4'd7; tick();
        coin_valid = 1'b1; coin_value = 4'd4; cancel = 1'b1; tick();
        clear_strobes();
        checks++;
        if ({change_valid, change_amount, coin_reject} !== {1'b1, 4'd7, 1'b1}) begin
            errors++;
            $display("FAIL cancel_coin: got v=%b amt=%0d rej=%b expected v=1 amt=7 rej=1",
                     change_valid, change_amount, coin_reject);
        end
        tick();
        checks++;
        if ({change_valid, busy} !== 2'b00) begin
            errors++;
            $display("FAIL cancel_rearm: got %b expected 00", {change_valid, busy});
        end
        // A zero-value coin leaves the panel collecting with no credit.
        coin_valid = 1'b1; coin_value = 4'd0; tick();
        coin_valid = 1'b0;
        cancel = 1'b1; tick();
        cancel = 1'b0;
        checks++;
        if ({change_valid, busy} !== 2'b00) begin
            errors++;
            $display("FAIL cancel_zero: got %b expected 00", {change_valid, busy});
        end
        tick();
        checks++;
        if (change_valid !== 1'b0) begin
            errors++;
            $display("FAIL cancel_zero_late: got %b expected 0", change_valid);
        end
    endtask

    task automatic test_reset_in_wait();
        coin_valid = 1'b1; coin_value = 4'd5;
        select_valid = 1'b1; select_code = 3'd2;
        qty_valid = 1'b1; qty = 4'd3;
        tick();
        clear_strobes();
        req_ready = 1'b1; tick();
        req_ready = 1'b0;
        tick(20);
        checks++;
        if ({busy, req_valid, change_valid} !== 3'b100) begin
            errors++;
            $display("FAIL wait_hold: got %b expected 100", {busy, req_valid, change_valid});
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({req_valid, change_valid, coin_reject, error_light, busy, customer_money,
             customer_request, quantity_request, change_amount} !== 20'b0) begin
            errors++;
            $display("FAIL wait_async_reset: got busy=%b money=%0d expected all 0",
                     busy, customer_money);
        end
        #3 rst = 1'b0;
        tick();
        checks++;
        if ({busy, change_valid} !== 2'b00) begin
            errors++;
            $display("FAIL wait_after_reset: got %b expected 00", {busy, change_valid});
        end
    endtask

`ifdef PANEL_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        coin_valid = 1'b1; coin_value = 4'd6;
        select_valid = 1'b1; select_code = 3'd1;
        qty_valid = 1'b1; qty = 4'd1;
        tick();
        clear_strobes();
        req_ready = 1'b1; tick();
        req_ready = 1'b0;
        n = 0;
        while (!change_valid && n < int'(TIMEOUT_CYCLES) + 10) begin
            tick();
            n++;
        end
        checks++;
        if (n != int'(TIMEOUT_CYCLES)) begin
            errors++;
            $display("FAIL timeout_cycles: got %0d expected %0d", n, TIMEOUT_CYCLES);
        end
        checks++;
        if ({change_valid, change_amount, error_light} !== {1'b1, 4'd6, 1'b1}) begin
            errors++;
            $display("FAIL timeout_refund: got v=%b amt=%0d err=%b expected v=1 amt=6 err=1",
                     change_valid, change_amount, error_light);
        end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_purchase();
        test_overflow();
        test_backpressure_refused();
        test_clamp();
        test_cancel_coin();
        test_reset_in_wait();
`ifdef PANEL_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
